// File: rtl/race_scene_ctrl.sv
// Racing-game VGA scene controller: paints verges, road and car sprite, then
// services left/right/straight requests by erasing, moving and redrawing the car.
module race_scene_ctrl #(
    parameter int SCR_W   = 160,
    parameter int SCR_H   = 120,
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int GRASS_W = 30,
    parameter int CAR_W   = 5,
    parameter int CAR_H   = 13,
    parameter int CAR_Y   = 105,
    parameter int STEP    = 4,
    parameter int CW      = 3,
    parameter logic [CW-1:0] C_GRASS = 3'b010,
    parameter logic [CW-1:0] C_ROAD  = 3'b000,
    parameter logic [CW-1:0] C_CAR   = 3'b100
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          left,
    input  logic          right,
    input  logic          straight,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot,
    output logic          ready,
    output logic          done,
    output logic [XW-1:0] car_x
);

    localparam int XW1 = XW + 1;
    localparam logic [XW-1:0] X_LAST     = XW'(SCR_W - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(SCR_H - 1);
    localparam logic [XW-1:0] SPR_X_LAST = XW'(CAR_W - 1);
    localparam logic [YW-1:0] SPR_Y_LAST = YW'(CAR_H - 1);
    localparam logic [XW-1:0] X_MIN      = XW'(GRASS_W);
    localparam logic [XW-1:0] X_MAX      = XW'(SCR_W - GRASS_W - CAR_W);
    localparam logic [XW-1:0] X_HOME     = XW'((SCR_W - CAR_W) / 2);
    localparam logic [XW-1:0] ROAD_END   = XW'(SCR_W - GRASS_W);
    localparam logic [YW-1:0] SPR_TOP    = YW'(CAR_Y);

    typedef enum logic [3:0] {
        S_BG, S_DONE_BG, S_DRAW_CAR, S_DONE_CAR, S_IDLE, S_WAIT_MOVE,
        S_ERASE, S_UPDATE, S_DRAW_MV, S_DONE_MV, S_ACK
    } state_t;

    state_t        state_q;
    logic [XW-1:0] cx_q;
    logic [YW-1:0] cy_q;
    logic [XW-1:0] car_x_q;
    logic          dir_left_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [CW-1:0] colour_q;
    logic          plot_q;
    logic          ready_q;
    logic          done_q;

    // One extra bit so a step below column 0 shows up as a borrow, not a wrap.
    function automatic logic [XW-1:0] move_left(input logic [XW-1:0] cur);
        logic [XW:0] diff;
        diff = {1'b0, cur} - XW1'(STEP);
        if (diff[XW] || (diff < XW1'(GRASS_W)))
            return X_MIN;
        return diff[XW-1:0];
    endfunction

    function automatic logic [XW-1:0] move_right(input logic [XW-1:0] cur);
        logic [XW:0] sum;
        sum = {1'b0, cur} + XW1'(STEP);
        if (sum > {1'b0, X_MAX})
            return X_MAX;
        return sum[XW-1:0];
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_BG;
            cx_q       <= '0;
            cy_q       <= '0;
            car_x_q    <= X_HOME;
            dir_left_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            plot_q     <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            plot_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            case (state_q)
                S_BG: begin
                    x_q      <= cx_q;
                    y_q      <= cy_q;
                    colour_q <= (cx_q < X_MIN || cx_q >= ROAD_END) ? C_GRASS : C_ROAD;
                    plot_q   <= 1'b1;
                    if (cx_q == X_LAST) begin
                        cx_q <= '0;
                        if (cy_q == Y_LAST) begin
                            cy_q    <= '0;
                            state_q <= S_DONE_BG;
                        end else begin
                            cy_q <= cy_q + 1'b1;
                        end
                    end else begin
                        cx_q <= cx_q + 1'b1;
                    end
                end
                S_DRAW_CAR, S_ERASE, S_DRAW_MV: begin
                    x_q      <= car_x_q + cx_q;
                    y_q      <= SPR_TOP + cy_q;
                    colour_q <= (state_q == S_ERASE) ? C_ROAD : C_CAR;
                    plot_q   <= 1'b1;
                    if (cx_q == SPR_X_LAST) begin
                        cx_q <= '0;
                        if (cy_q == SPR_Y_LAST) begin
                            cy_q <= '0;
                            if (state_q == S_ERASE)
                                state_q <= S_UPDATE;
                            else if (state_q == S_DRAW_CAR)
                                state_q <= S_DONE_CAR;
                            else
                                state_q <= S_DONE_MV;
                        end else begin
                            cy_q <= cy_q + 1'b1;
                        end
                    end else begin
                        cx_q <= cx_q + 1'b1;
                    end
                end
                S_DONE_BG: begin
                    done_q  <= 1'b1;
                    state_q <= S_DRAW_CAR;
                end
                S_DONE_CAR: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (start) begin
                        ready_q <= 1'b1;
                        state_q <= S_WAIT_MOVE;
                    end
                end
                S_WAIT_MOVE: begin
                    // Both directions at once cancel out and count as straight.
                    if (left && right) begin
                        state_q <= S_ACK;
                    end else if (left) begin
                        dir_left_q <= 1'b1;
                        state_q    <= S_ERASE;
                    end else if (right) begin
                        dir_left_q <= 1'b0;
                        state_q    <= S_ERASE;
                    end else if (straight) begin
                        state_q <= S_ACK;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    car_x_q <= dir_left_q ? move_left(car_x_q) : move_right(car_x_q);
                    state_q <= S_DRAW_MV;
                end
                S_DONE_MV, S_ACK: begin
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= S_WAIT_MOVE;
                end
                default: state_q <= S_BG;
            endcase
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign ready  = ready_q;
    assign done   = done_q;
    assign car_x  = car_x_q;

endmodule

// File: tb/tb_race_scene_ctrl.sv
// Randomised bench for race_scene_ctrl against a pixel-list reference model.
module tb_race_scene_ctrl;

    logic       clock, reset, start, left, right, straight;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, ready, done;
    logic [7:0] car_x;

    int n_vec = 0;
    int n_bad = 0;
    int model_x = 77;
    logic [17:0] obs_px[$];
    int          obs_cyc[$];

    race_scene_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .left(left), .right(right),
        .straight(straight), .x(x), .y(y), .colour(colour), .plot(plot),
        .ready(ready), .done(done), .car_x(car_x)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [17:0] pix(input int px, input int py, input int pc);
        logic [7:0] a;
        logic [6:0] b;
        logic [2:0] c;
        a = 8'(px);
        b = 7'(py);
        c = 3'(pc);
        return {a, b, c};
    endfunction

    // Records every plotted pixel until a done pulse is seen or the budget runs out.
    task automatic capture(input int budget, input bit inject, output bit got_done);
        int n = 0;
        got_done = 1'b0;
        obs_px.delete();
        obs_cyc.delete();
        while (n < budget) begin
            if (plot) begin
                obs_px.push_back({x, y, colour});
                obs_cyc.push_back(n);
            end
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (inject && obs_px.size() == 80) left = 1'b1;
            if (inject && obs_px.size() == 90) left = 1'b0;
            @(negedge clock);
            n++;
        end
        chk("seq_done", 32'(got_done), 1);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        @(negedge clock);
        chk("rst_plot", 32'(plot), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_xyc", {x, y, colour}, 0);
        chk("rst_car_x", 32'(car_x), 77);
        reset = 1'b0;
        model_x = 77;
    endtask

    task automatic check_sprite(input string tag, input int px, input int pc, input int base);
        int bad = 0;
        for (int i = 0; i < 65; i++)
            if (base + i < obs_px.size())
                if (obs_px[base + i] !== pix(px + i % 5, 105 + i / 5, pc)) bad++;
        chk(tag, bad, 0);
    endtask

    // Background, car and start handshake; start is held through the background.
    task automatic init_seq();
        bit got;
        int bad = 0;
        start = 1'b1;
        capture(19400, 1'b0, got);
        start = 1'b0;
        chk("bg_len", obs_px.size(), 19200);
        for (int i = 0; i < obs_px.size() && i < 19200; i++) begin
            int xx = i % 160;
            if (obs_px[i] !== pix(xx, i / 160, (xx < 30 || xx >= 130) ? 2 : 0)) bad++;
        end
        chk("bg_pix_bad", bad, 0);
        if (obs_px.size() == 19200) begin
            chk("bg_first", obs_px[0], pix(0, 0, 2));
            chk("bg_29_0", obs_px[29], pix(29, 0, 2));
            chk("bg_30_0", obs_px[30], pix(30, 0, 0));
            chk("bg_129_0", obs_px[129], pix(129, 0, 0));
            chk("bg_130_0", obs_px[130], pix(130, 0, 2));
            chk("bg_contig", obs_cyc[19199] - obs_cyc[0], 19199);
        end
        @(negedge clock);
        chk("bg_done_pulse", 32'(done), 0);
        capture(200, 1'b0, got);
        chk("car_len", obs_px.size(), 65);
        check_sprite("car_pix_bad", 77, 4, 0);
        @(negedge clock);
        chk("car_done_pulse", 32'(done), 0);
        repeat (3) @(negedge clock);
        chk("idle_ready", 32'(ready), 0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("start_ready", 32'(ready), 1);
    endtask

    task automatic do_req(input bit l, input bit r, input bit s, input bit inject);
        bit got;
        int w = 0;
        int old_x = model_x;
        bit is_move = l ^ r;
        while (!ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        chk("req_ready", 32'(ready), 1);
        left = l; right = r; straight = s;
        @(negedge clock);
        left = 1'b0; right = 1'b0; straight = 1'b0;
        capture(400, inject && is_move, got);
        left = 1'b0;
        if (is_move) begin
            if (l) model_x = (old_x - 4 < 30) ? 30 : old_x - 4;
            else   model_x = (old_x + 4 > 125) ? 125 : old_x + 4;
            chk("mv_len", obs_px.size(), 130);
            check_sprite("erase_pix_bad", old_x, 0, 0);
            check_sprite("draw_pix_bad", model_x, 4, 65);
            if (obs_px.size() == 130) begin
                chk("erase_contig", obs_cyc[64] - obs_cyc[0], 64);
                chk("update_gap", obs_cyc[65] - obs_cyc[64] - 1, 1);
            end
        end else begin
            chk("ack_plots", obs_px.size(), 0);
        end
        chk("car_x", 32'(car_x), 32'(model_x));
        chk("ready_back", 32'(ready), 1);
        @(negedge clock);
        chk("done_pulse", 32'(done), 0);
    endtask

    initial begin
        bit saw;
        int w;
        reset = 1'b0; start = 1'b0; left = 1'b0; right = 1'b0; straight = 1'b0;
        reset_dut();
        init_seq();

        do_req(1, 0, 0, 0);
        repeat (14) do_req(1, 0, 0, 0);
        do_req(1, 1, 0, 0);
        do_req(0, 0, 1, 0);
        do_req(1, 1, 1, 0);
        repeat (26) do_req(0, 1, 0, 0);
        do_req(0, 1, 0, 1);
        for (int k = 0; k < 30; k++) begin
            int sel = $urandom_range(0, 5);
            bit inj = $urandom_range(0, 1);
            case (sel)
                0, 1: do_req(1, 0, $urandom_range(0, 1), inj);
                2, 3: do_req(0, 1, $urandom_range(0, 1), inj);
                4:    do_req(1, 1, $urandom_range(0, 1), 0);
                default: do_req(0, 0, 1, 0);
            endcase
        end

        // Reset in the middle of an erase pass.
        w = 0;
        while (!ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        left = 1'b1;
        @(negedge clock);
        left = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 10 && !saw; i++) begin
            @(negedge clock);
            saw = plot;
        end
        chk("erase_started", 32'(saw), 1);
        repeat (10) @(negedge clock);
        reset_dut();
        init_seq();
        do_req(1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
